decim_avg_ctrl: RTL and testbench

//   Accumulate-and-dump averaging stage that sits directly upstream of the

---
 rtl/decim_avg_ctrl.sv | 83 ++++++++
 tb/tb_decim_avg_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/decim_avg_ctrl.sv
// Accumulate-and-dump averager feeding the decimator register: sums 2^k valid
// samples, emits their floor mean once per frame and pulses hold low for one cycle.
module decim_avg_ctrl #(
    parameter int word_length = 8,
    parameter int LOG2_MAX    = 3,
    parameter int RS_W        = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [word_length-1:0] data_in,
    input  logic                   data_valid,
    input  logic [RS_W-1:0]        rate_sel,
    output logic [word_length-1:0] data_out,
    output logic                   hold
);

    localparam int ACC_W = word_length + LOG2_MAX;
    localparam int K_W   = (LOG2_MAX < 1) ? 1 : $clog2(LOG2_MAX + 1);
    localparam int CNT_W = (LOG2_MAX < 1) ? 1 : LOG2_MAX;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic signed [ACC_W-1:0]    acc_r;
    logic        [CNT_W-1:0]    cnt_r;
    logic        [K_W-1:0]      k_r;

    logic signed [ACC_W-1:0]    sample_ext_s;
    logic signed [ACC_W-1:0]    sum_s;
    logic        [CNT_W-1:0]    last_cnt_s;
    logic                       frame_end_s;
    logic        [K_W-1:0]      rate_clamped_s;
    logic        [word_length-1:0] avg_word_s;

    // Requests above the largest supported rate saturate to LOG2_MAX.
    function automatic logic [K_W-1:0] clamp_rate(input logic [RS_W-1:0] rs);
        if (int'(rs) > LOG2_MAX) begin
            return K_W'(LOG2_MAX);
        end else begin
            return K_W'(rs);
        end
    endfunction

    // Next-sum, frame-end detection and the shifted (floor) average.
    always_comb begin
        rate_clamped_s = clamp_rate(rate_sel);
        sample_ext_s   = ACC_W'($signed(data_in));
        sum_s          = acc_r + sample_ext_s;
        last_cnt_s     = CNT_W'((32'd1 << k_r) - 32'd1);
        frame_end_s    = (cnt_r == last_cnt_s);
        avg_word_s     = word_length'(sum_s >>> k_r);
    end

    // Accumulator, sample counter, active rate and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_r    <= {ACC_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            k_r      <= rate_clamped_s;
            data_out <= {word_length{1'b0}};
            hold     <= 1'b1;
        end else if (data_valid) begin
            if (frame_end_s) begin
                acc_r    <= {ACC_W{1'b0}};
                cnt_r    <= {CNT_W{1'b0}};
                k_r      <= rate_clamped_s;
                data_out <= avg_word_s;
                hold     <= 1'b0;
            end else begin
                acc_r    <= sum_s;
                cnt_r    <= cnt_r + CNT_ONE;
                k_r      <= k_r;
                data_out <= data_out;
                hold     <= 1'b1;
            end
        end else begin
            acc_r    <= acc_r;
            cnt_r    <= cnt_r;
            k_r      <= k_r;
            data_out <= data_out;
            hold     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decim_avg_ctrl.sv
// Scoreboard bench for decim_avg_ctrl: a frame-level reference model pushes
// expected averages; a monitor pops them whenever hold drops.
module tb_decim_avg_ctrl;

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       data_valid = 1'b0;
    logic [1:0] rate_sel = 2'd0;
    logic [2:0] rate_sel_w = 3'd7;
    logic [7:0] data_out0;
    logic       hold0;
    logic [7:0] data_out1;
    logic       hold1;

    int   cyc = 0;
    logic rst_seen = 1'b0;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   passed = 0;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   cur_exp[2];
    int   frame_sum[2];
    int   frame_cnt[2];
    int   frame_k[2];

    decim_avg_ctrl #(.word_length(8), .LOG2_MAX(3), .RS_W(2)) u_dut (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .rate_sel(rate_sel), .data_out(data_out0), .hold(hold0)
    );

    // Widened rate select permanently requesting 7, which must clamp to 3.
    decim_avg_ctrl #(.word_length(8), .LOG2_MAX(3), .RS_W(3)) u_dut_w (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .rate_sel(rate_sel_w), .data_out(data_out1), .hold(hold1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    function automatic int clamp3(input int rs);
        return (rs > 3) ? 3 : rs;
    endfunction

    // Mean of 2^k samples rounded toward minus infinity.
    function automatic int floor_mean(input int s, input int k);
        int n;
        n = 1 << k;
        if (s >= 0) return s / n;
        return -((-s + n - 1) / n);
    endfunction

    task automatic model_reset(input int rs);
        for (int ch = 0; ch < 2; ch++) begin
            frame_sum[ch] = 0;
            frame_cnt[ch] = 0;
        end
        frame_k[0] = clamp3(rs);
        frame_k[1] = clamp3(7);
    endtask

    task automatic do_reset(input int rs);
        @(posedge clock); #1;
        reset = 1'b1; data_valid = 1'b1; data_in = 8'd55; rate_sel = 2'(rs);
        model_reset(rs);
        @(posedge clock); #1;
        model_reset(rs);
        mon_en = 1'b1;
    endtask

    task automatic step(input bit v, input int d, input int rs);
        exp_t e;
        @(posedge clock); #1;
        reset = 1'b0; data_valid = v; data_in = 8'(d); rate_sel = 2'(rs);
        if (v) begin
            for (int ch = 0; ch < 2; ch++) begin
                frame_sum[ch] += d;
                frame_cnt[ch] += 1;
                if (frame_cnt[ch] == (1 << frame_k[ch])) begin
                    e.data = floor_mean(frame_sum[ch], frame_k[ch]);
                    e.cyc  = cyc + 1;
                    if (ch == 0) exp_q0.push_back(e);
                    else         exp_q1.push_back(e);
                    frame_sum[ch] = 0;
                    frame_cnt[ch] = 0;
                    frame_k[ch]   = (ch == 0) ? clamp3(rs) : clamp3(7);
                end
            end
        end
    endtask

    task automatic check_ch(input int ch, input logic h, input logic [7:0] dout);
        exp_t e;
        bit   have;
        if (rst_seen) cur_exp[ch] = 0;
        have = (ch == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
        if (have) begin
            e = (ch == 0) ? exp_q0[0] : exp_q1[0];
            if (e.cyc < cyc) begin
                checks++;
                $display("FAIL missed_hold ch%0d: hold never dropped, required at cycle %0d (now %0d)", ch, e.cyc, cyc);
                if (ch == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
                cur_exp[ch] = e.data;
                have = (ch == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
                if (have) e = (ch == 0) ? exp_q0[0] : exp_q1[0];
            end
        end
        if (h === 1'b0) begin
            checks++;
            if (!have) begin
                $display("FAIL unexpected_hold ch%0d: hold=0 at cycle %0d, required 1", ch, cyc);
            end else begin
                if (ch == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
                cur_exp[ch] = e.data;
                if (e.cyc == cyc) passed++;
                else $display("FAIL hold_timing ch%0d: hold low at cycle %0d, required cycle %0d", ch, cyc, e.cyc);
            end
        end else if (h !== 1'b1) begin
            checks++;
            $display("FAIL hold_x ch%0d: hold=%b at cycle %0d, required 1", ch, h, cyc);
        end
        checks++;
        if (dout === 8'(cur_exp[ch])) passed++;
        else $display("FAIL data_out ch%0d: got %0d (0x%h) at cycle %0d, required %0d",
                      ch, $signed(dout), dout, cyc, cur_exp[ch]);
    endtask

    // Monitor: sample outputs mid-cycle and score them against the queues.
    always @(negedge clock) begin
        if (mon_en) begin
            check_ch(0, hold0, data_out0);
            check_ch(1, hold1, data_out1);
        end
    end

    initial begin
        cur_exp[0] = 0;
        cur_exp[1] = 0;
        model_reset(0);

        // Reset while data_valid=1 with 55 presented: nothing accumulates.
        do_reset(2);
        step(1'b0, 0, 2);
        // Consecutive 4,8,12,16 -> 10.
        step(1'b1, 4, 2); step(1'b1, 8, 2); step(1'b1, 12, 2); step(1'b1, 16, 2);
        step(1'b0, 0, 2);
        // -1..-4 with bubbles -> floor(-2.5) = -3.
        step(1'b1, -1, 2); step(1'b0, 0, 2); step(1'b1, -2, 2); step(1'b0, 0, 2);
        step(1'b1, -3, 2); step(1'b0, 0, 2); step(1'b1, -4, 2); step(1'b0, 0, 2);
        // Rate change 2->1 mid-frame; next frame 6,9 -> 7.
        step(1'b1, 1, 2); step(1'b1, 2, 2); step(1'b1, 3, 1); step(1'b1, 4, 1);
        step(1'b1, 6, 1); step(1'b1, 9, 3);
        // k=3 extremes, aligned to frames of both instances.
        do_reset(3);
        for (int i = 0; i < 8; i++) step(1'b1, 127, 3);
        for (int i = 0; i < 8; i++) step(1'b1, -128, 3);
        for (int i = 0; i < 7; i++) step(1'b1, -128, 3);
        step(1'b1, -128, 0);
        // k=0 pass-through.
        step(1'b1, 5, 0); step(1'b1, -7, 0); step(1'b1, 9, 2);
        step(1'b0, 0, 2);
        // Reset mid-frame at k=2 then a clean frame.
        step(1'b1, 100, 2); step(1'b1, 90, 2);
        do_reset(2);
        step(1'b1, 3, 2); step(1'b1, -9, 2); step(1'b1, 20, 2); step(1'b1, 7, 2);
        step(1'b0, 0, 2);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset(int'($urandom_range(0, 3)));
            end else begin
                step($urandom_range(0, 9) < 7, int'($urandom_range(0, 255)) - 128,
                     int'($urandom_range(0, 3)));
            end
        end
        for (int i = 0; i < 4; i++) step(1'b0, 0, 0);
        @(negedge clock); #1;

        checks++;
        if (exp_q0.size() == 0) passed++;
        else $display("FAIL drain ch0: %0d averages never emitted, required 0", exp_q0.size());
        checks++;
        if (exp_q1.size() == 0) passed++;
        else $display("FAIL drain ch1: %0d averages never emitted, required 0", exp_q1.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
